// File: rtl/tcp_tx_frame_arbiter.sv
// tcp_tx_frame_arbiter
//   Round-robin scheduler that shares the single SiTCP TCP TX byte port among
//   N_SRC framed byte-stream producers. Ownership is granted for a whole frame.
//   Rotation is forced after MAX_FRAME payload bytes. The arbiter stalls on
//   TCP_TX_FULL and drops the current frame when TCP_OPEN_ACK falls.
//
//   Optional build macro: TCP_TX_HDR_EN
//     When defined, one tag byte {4'hA, 1'b0, id[2:0]} is emitted at the start
//     of every grant, before the payload.
//
// Ports
//   CLK           in   system clock (SiTCP clock)
//   RST           in   synchronous reset, active-high
//   TCP_OPEN_ACK  in   SiTCP connection open
//   TCP_TX_FULL   in   SiTCP TX almost-full
//   TCP_TX_WR     out  registered write strobe to SiTCP
//   TCP_TX_DATA   out  registered write byte to SiTCP
//   SRC_VALID     in   per-source byte valid
//   SRC_DATA      in   per-source byte, source i at [8*i +: 8]
//   SRC_LAST      in   per-source last-byte-of-frame, qualified by SRC_VALID
//   SRC_RDY       out  per-source accept (combinational)
//   GRANT         out  one-hot current owner, zero while idle
//   BUSY          out  arbiter not idle
//
// FSM states
//   state    | meaning
//   ST_IDLE  | no owner; pick the next requester round-robin
//   ST_HDR   | owner chosen; emit the tag byte (TCP_TX_HDR_EN builds only)
//   ST_DATA  | owner streams payload bytes until LAST or MAX_FRAME

module tcp_tx_frame_arbiter #(
   parameter int N_SRC     = 4,
   parameter int MAX_FRAME = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 TCP_OPEN_ACK,
   input  logic                 TCP_TX_FULL,
   output logic                 TCP_TX_WR,
   output logic [7:0]           TCP_TX_DATA,
   input  logic [N_SRC-1:0]     SRC_VALID,
   input  logic [8*N_SRC-1:0]   SRC_DATA,
   input  logic [N_SRC-1:0]     SRC_LAST,
   output logic [N_SRC-1:0]     SRC_RDY,
   output logic [N_SRC-1:0]     GRANT,
   output logic                 BUSY
);

   localparam int               PTR_W   = $clog2(N_SRC);
   localparam logic [15:0]      MAX_CNT = 16'(MAX_FRAME);
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_SRC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               tx_wr_q, tx_wr_d;
   logic [7:0]         tx_data_q, tx_data_d;

   logic               sel_valid;
   logic               sel_last;
   logic [7:0]         sel_data;
   logic               link_ok;
   logic               xfer;
   logic [15:0]        cnt_inc;
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   cand;

   // Owner's byte stream, selected by the one-hot grant
   always_comb begin
      sel_data = 8'h00;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            sel_data = sel_data | SRC_DATA[8*i +: 8];
         end
      end
   end

   assign sel_valid = |(SRC_VALID & grant_q);
   assign sel_last  = |(SRC_LAST & grant_q);
   assign link_ok   = TCP_OPEN_ACK & ~TCP_TX_FULL;
   assign xfer      = (state_q == ST_DATA) & link_ok & sel_valid;
   assign cnt_inc   = cnt_q + 16'd1;

   assign SRC_RDY     = ((state_q == ST_DATA) && link_ok) ? grant_q : '0;
   assign GRANT       = grant_q;
   assign BUSY        = (state_q != ST_IDLE);
   assign TCP_TX_WR   = tx_wr_q;
   assign TCP_TX_DATA = tx_data_q;

   // Round-robin search starting at ptr+1. The scan runs from the far end
   // backwards so that the last hit is the one closest to ptr+1.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         cand = PTR_W'((int'(ptr_q) + k) % N_SRC);
         if (SRC_VALID[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      tx_wr_d   = 1'b0;
      tx_data_d = tx_data_q;

      case (state_q)
         ST_IDLE: begin
            if (TCP_OPEN_ACK && win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               ptr_d            = win_idx;
               cnt_d            = 16'd0;
`ifdef TCP_TX_HDR_EN
               state_d          = ST_HDR;
`else
               state_d          = ST_DATA;
`endif
            end
         end

`ifdef TCP_TX_HDR_EN
         ST_HDR: begin
            if (!TCP_OPEN_ACK) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else if (!TCP_TX_FULL) begin
               tx_wr_d   = 1'b1;
               tx_data_d = {4'hA, 1'b0, 3'(ptr_q)};
               state_d   = ST_DATA;
            end
         end
`endif

         ST_DATA: begin
            if (!TCP_OPEN_ACK) begin
               // connection lost: truncate the frame
               state_d = ST_IDLE;
               grant_d = '0;
            end else if (xfer) begin
               tx_wr_d   = 1'b1;
               tx_data_d = sel_data;
               cnt_d     = cnt_inc;
               // LAST and a full MAX_FRAME on the same byte take the same single exit
               if (sel_last || (cnt_inc == MAX_CNT)) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         ptr_q     <= PTR_RST;
         cnt_q     <= 16'd0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         tx_wr_q   <= tx_wr_d;
         tx_data_q <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_tcp_tx_frame_arbiter.sv
module tb_tcp_tx_frame_arbiter;

   localparam int N = 4;

   logic           CLK;
   logic           RST;
   logic           TCP_OPEN_ACK;
   logic           TCP_TX_FULL;
   logic           TCP_TX_WR;
   logic [7:0]     TCP_TX_DATA;
   logic [N-1:0]   SRC_VALID;
   logic [8*N-1:0] SRC_DATA;
   logic [N-1:0]   SRC_LAST;
   logic [N-1:0]   SRC_RDY;
   logic [N-1:0]   GRANT;
   logic           BUSY;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // source byte stores: bit 8 = last
   logic [8:0] smem [N][64];
   int         swr [N];
   int         srd [N];

   logic [7:0] wr_log  [$];
   int         wr_cyc  [$];
   int         wr_gn   [$];
   int         fire_cyc[$];
   int         gnt_log [$];

   tcp_tx_frame_arbiter #(.N_SRC(N), .MAX_FRAME(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .TCP_OPEN_ACK (TCP_OPEN_ACK),
      .TCP_TX_FULL  (TCP_TX_FULL),
      .TCP_TX_WR    (TCP_TX_WR),
      .TCP_TX_DATA  (TCP_TX_DATA),
      .SRC_VALID    (SRC_VALID),
      .SRC_DATA     (SRC_DATA),
      .SRC_LAST     (SRC_LAST),
      .SRC_RDY      (SRC_RDY),
      .GRANT        (GRANT),
      .BUSY         (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic int oh_idx(input logic [N-1:0] g);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (g[i]) r = i;
      return r;
   endfunction

   // source models: present queue heads on negedge, pop on accepted handshake
   initial begin : src_drv
      logic [N-1:0]   v, l, fire;
      logic [8*N-1:0] d;
      for (int i = 0; i < N; i++) begin
         swr[i] = 0;
         srd[i] = 0;
      end
      SRC_VALID = '0;
      SRC_DATA  = '0;
      SRC_LAST  = '0;
      forever begin
         @(negedge CLK);
         v = '0; l = '0; d = '0;
         for (int i = 0; i < N; i++) begin
            if (srd[i] < swr[i]) begin
               v[i]        = 1'b1;
               d[8*i +: 8] = smem[i][srd[i]][7:0];
               l[i]        = smem[i][srd[i]][8];
            end
         end
         SRC_VALID = v;
         SRC_DATA  = d;
         SRC_LAST  = l;
         #4;
         fire = SRC_VALID & SRC_RDY;
         if (fire != '0) fire_cyc.push_back(cyc);
         @(posedge CLK);
         for (int i = 0; i < N; i++) if (fire[i]) srd[i] = srd[i] + 1;
      end
   end

   // TX port and grant monitor
   initial begin : mon
      logic [N-1:0] prev_g;
      prev_g = '0;
      forever begin
         @(posedge CLK);
         cyc = cyc + 1;
         #1;
         if (TCP_TX_WR) begin
            wr_log.push_back(TCP_TX_DATA);
            wr_cyc.push_back(cyc);
            wr_gn.push_back(gnt_log.size());
         end
         if (prev_g == '0 && GRANT != '0) gnt_log.push_back(oh_idx(GRANT));
         prev_g = GRANT;
      end
   end

   task automatic push_bytes(input int s, input int n, input logic [7:0] base, input logic last_end);
      for (int k = 0; k < n; k++) begin
         smem[s][swr[s]] = {(last_end && k == n - 1), base + 8'(k)};
         swr[s] = swr[s] + 1;
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      wr_cyc.delete();
      wr_gn.delete();
      fire_cyc.delete();
      gnt_log.delete();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int  n;
      bit  done;
      done = 1'b0;
      n    = 0;
      while (!done && n < budget) begin
         @(negedge CLK);
         n = n + 1;
         done = !BUSY && !TCP_TX_WR;
         for (int i = 0; i < N; i++) if (srd[i] != swr[i]) done = 1'b0;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: not idle after %0d cycles, wanted idle", name, budget);
      end
   endtask

   task automatic wait_writes(input string name, input int cnt, input int budget);
      int n;
      n = 0;
      while (wr_log.size() < cnt && n < budget) begin
         @(negedge CLK);
         n = n + 1;
      end
      checks++;
      if (wr_log.size() < cnt) begin
         errors++;
         $display("FAIL %s timeout: got %0d writes, wanted %0d", name, wr_log.size(), cnt);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      TCP_OPEN_ACK = 1'b1;
      TCP_TX_FULL  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (TCP_TX_WR !== 1'b0)    begin errors++; $display("FAIL rst_wr got %b want 0", TCP_TX_WR); end
      checks++; if (TCP_TX_DATA !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", TCP_TX_DATA); end
      checks++; if (GRANT !== 4'b0000)     begin errors++; $display("FAIL rst_grant got %b want 0000", GRANT); end
      checks++; if (BUSY !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
      checks++; if (SRC_RDY !== 4'b0000)   begin errors++; $display("FAIL rst_rdy got %b want 0000", SRC_RDY); end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_single_frame();
      logic [7:0] exp [3];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      clear_logs();
      @(posedge CLK); #2;
      smem[0][swr[0]] = {1'b0, 8'h11}; swr[0]++;
      smem[0][swr[0]] = {1'b0, 8'h22}; swr[0]++;
      smem[0][swr[0]] = {1'b1, 8'h33}; swr[0]++;
      wait_done("single", 50);
      checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL single_count got %0d want 3", wr_log.size()); end
      for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] !== exp[i]) begin errors++; $display("FAIL single_data[%0d] got %h want %h", i, wr_log[i], exp[i]); end
      end
      checks++; if (fire_cyc.size() != 3) begin errors++; $display("FAIL single_fires got %0d want 3", fire_cyc.size()); end
      for (int i = 0; i < 3 && i < wr_cyc.size() && i < fire_cyc.size(); i++) begin
         checks++;
         if (wr_cyc[i] != fire_cyc[i] + 1) begin errors++; $display("FAIL single_latency[%0d] got %0d want %0d", i, wr_cyc[i], fire_cyc[i] + 1); end
      end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", BUSY); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp [10];
      int         expg [5];
      exp = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h05, 8'h06};
      expg = '{0, 1, 2, 3, 0};
      do_reset();
      clear_logs();
      @(posedge CLK); #2;
      push_bytes(0, 2, 8'h01, 1'b1);
      push_bytes(0, 2, 8'h05, 1'b1);
      push_bytes(1, 2, 8'h11, 1'b1);
      push_bytes(2, 2, 8'h21, 1'b1);
      push_bytes(3, 2, 8'h31, 1'b1);
      wait_done("rr", 100);
      checks++; if (wr_log.size() != 10) begin errors++; $display("FAIL rr_count got %0d want 10", wr_log.size()); end
      for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] !== exp[i]) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", i, wr_log[i], exp[i]); end
      end
      checks++; if (gnt_log.size() != 5) begin errors++; $display("FAIL rr_grants got %0d want 5", gnt_log.size()); end
      for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
         checks++;
         if (gnt_log[i] != expg[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, gnt_log[i], expg[i]); end
      end
   endtask

   task automatic test_max_frame();
      int grp [4];
      grp = '{0, 0, 0, 0};
      clear_logs();
      @(posedge CLK); #2;
      push_bytes(1, 10, 8'h40, 1'b1);
      wait_done("maxf", 100);
      checks++; if (wr_log.size() != 10) begin errors++; $display("FAIL maxf_count got %0d want 10", wr_log.size()); end
      for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL maxf_data[%0d] got %h want %h", i, wr_log[i], 8'h40 + 8'(i)); end
         if (wr_gn[i] >= 0 && wr_gn[i] < 4) grp[wr_gn[i]]++;
      end
      checks++; if (grp[1] != 4 || grp[2] != 4 || grp[3] != 2) begin
         errors++; $display("FAIL maxf_groups got %0d,%0d,%0d want 4,4,2", grp[1], grp[2], grp[3]);
      end
      checks++; if (gnt_log.size() != 3) begin errors++; $display("FAIL maxf_grants got %0d want 3", gnt_log.size()); end
      for (int i = 0; i < gnt_log.size(); i++) begin
         checks++;
         if (gnt_log[i] != 1) begin errors++; $display("FAIL maxf_owner[%0d] got %0d want 1", i, gnt_log[i]); end
      end
   endtask

   task automatic test_last_at_max();
      int grp [4];
      grp = '{0, 0, 0, 0};
      clear_logs();
      @(posedge CLK); #2;
      push_bytes(2, 4, 8'h50, 1'b1);
      push_bytes(2, 2, 8'h54, 1'b1);
      wait_done("lastmax", 80);
      for (int i = 0; i < wr_gn.size(); i++) if (wr_gn[i] >= 0 && wr_gn[i] < 4) grp[wr_gn[i]]++;
      checks++; if (gnt_log.size() != 2) begin errors++; $display("FAIL lastmax_grants got %0d want 2", gnt_log.size()); end
      checks++; if (grp[1] != 4 || grp[2] != 2) begin
         errors++; $display("FAIL lastmax_groups got %0d,%0d want 4,2", grp[1], grp[2]);
      end
      checks++; if (wr_log.size() != 6 || wr_log[5] !== 8'h55) begin
         errors++; $display("FAIL lastmax_tail got %0d writes want 6 ending 55", wr_log.size());
      end
   endtask

   task automatic test_full_stall();
      int n0;
      clear_logs();
      @(posedge CLK); #2;
      push_bytes(0, 4, 8'h60, 1'b1);
      wait_writes("full_pre", 2, 40);
      TCP_TX_FULL = 1'b1;
      #1;
      checks++; if (SRC_RDY !== 4'b0000) begin errors++; $display("FAIL full_rdy got %b want 0000", SRC_RDY); end
      checks++; if (GRANT !== 4'b0001)   begin errors++; $display("FAIL full_hold got %b want 0001", GRANT); end
      n0 = wr_log.size();
      repeat (5) @(negedge CLK);
      checks++; if (wr_log.size() - n0 > 1) begin errors++; $display("FAIL full_extra got %0d writes want <=1", wr_log.size() - n0); end
      TCP_TX_FULL = 1'b0;
      wait_done("full", 60);
      checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL full_count got %0d want 4", wr_log.size()); end
      for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] !== 8'h60 + 8'(i)) begin errors++; $display("FAIL full_data[%0d] got %h want %h", i, wr_log[i], 8'h60 + 8'(i)); end
      end
   endtask

   task automatic test_open_drop();
      clear_logs();
      @(posedge CLK); #2;
      push_bytes(2, 5, 8'h70, 1'b1);
      wait_writes("open_pre", 2, 40);
      TCP_OPEN_ACK = 1'b0;
      #1;
      checks++; if (SRC_RDY !== 4'b0000) begin errors++; $display("FAIL open_rdy got %b want 0000", SRC_RDY); end
      repeat (6) @(negedge CLK);
      checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL open_nowr got %0d writes want 2", wr_log.size()); end
      checks++; if (GRANT !== 4'b0000)  begin errors++; $display("FAIL open_grant got %b want 0000", GRANT); end
      checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL open_busy got %b want 0", BUSY); end
      checks++; if (gnt_log.size() != 1) begin errors++; $display("FAIL open_regrant got %0d grants want 1", gnt_log.size()); end
      TCP_OPEN_ACK = 1'b1;
      wait_done("open", 60);
      checks++; if (wr_log.size() != 5) begin errors++; $display("FAIL open_resume got %0d writes want 5", wr_log.size()); end
      for (int i = 2; i < 5 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] !== 8'h70 + 8'(i)) begin errors++; $display("FAIL open_data[%0d] got %h want %h", i, wr_log[i], 8'h70 + 8'(i)); end
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_logs();
      @(posedge CLK); #2;
      push_bytes(3, 5, 8'h80, 1'b1);
      wait_writes("rstmid_pre", 2, 40);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      checks++; if (TCP_TX_WR !== 1'b0)    begin errors++; $display("FAIL rstmid_wr got %b want 0", TCP_TX_WR); end
      checks++; if (GRANT !== 4'b0000)     begin errors++; $display("FAIL rstmid_grant got %b want 0000", GRANT); end
      checks++; if (TCP_TX_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", TCP_TX_DATA); end
      for (int i = 0; i < N; i++) srd[i] = swr[i];
      @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL rstmid_nowr got %0d writes want 2", wr_log.size()); end
      checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b want 0", BUSY); end
   endtask

`ifdef TCP_TX_HDR_EN
   task automatic test_hdr();
      logic [7:0] exp [3];
      exp[0] = 8'hA3; exp[1] = 8'hAA; exp[2] = 8'hBB;
      do_reset();
      clear_logs();
      @(posedge CLK); #2;
      smem[3][swr[3]] = {1'b0, 8'hAA}; swr[3]++;
      smem[3][swr[3]] = {1'b1, 8'hBB}; swr[3]++;
      wait_done("hdr", 50);
      checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL hdr_count got %0d want 3", wr_log.size()); end
      for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] !== exp[i]) begin errors++; $display("FAIL hdr_data[%0d] got %h want %h", i, wr_log[i], exp[i]); end
      end
   endtask
`endif

   initial begin
      RST          = 1'b1;
      TCP_OPEN_ACK = 1'b1;
      TCP_TX_FULL  = 1'b0;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_max_frame();
      test_last_at_max();
      test_full_stall();
      test_open_drop();
      test_reset_mid_frame();
`ifdef TCP_TX_HDR_EN
      test_hdr();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
